// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_pkg
// Purpose : Shared constants and types for the two-port data-memory arbiter.
//           Provides the default address/data widths, the memory depth, and
//           the FSM state encoding used by mem_arbiter2.
// Ports   : (package, no ports)
// Rev     : 1.0  initial release
// ============================================================================
package mem_pkg;

   localparam int ADDR_W_DEF = 7;
   localparam int DATA_W_DEF = 32;
   localparam int MEM_DEPTH  = 128;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE   = S_IDLE,
      ST_ACCESS = S_ACCESS,
      ST_DONE   = S_DONE
   } state_e;

   // Port identifiers used for grant / last-grant bookkeeping.
   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/mem_arbiter2_rr_pick2.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick2
// Purpose : Combinational two-way round-robin pick.
// Ports   : req[1:0]  in   request vector (bit 0 = port A, bit 1 = port B)
//           last_gnt  in   port granted last time (0 = A, 1 = B)
//           gnt[1:0]  out  one-hot grant, all zero when nobody requests
// Rev     : 1.0  initial release
// ============================================================================
module rr_pick2
   import mem_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_gnt,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      unique case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         // Contention: the port that did not win last time goes next.
         2'b11:   gnt = (last_gnt == PORT_B) ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

endmodule : rr_pick2
`default_nettype wire

// File: rtl/mem_arbiter2.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter2
// Purpose : Two-port req/ack arbiter and sequencer for a 128x32 data memory.
//           One transaction = IDLE (arbitrate) -> ACCESS (drive memory) ->
//           DONE (ack). All memory pins and acks come straight from flops.
// Ports   : clk, rst_n                     clock / async active-low reset
//           a_req,a_we,a_addr,a_wdata      port A request side
//           a_ack,a_rdata                  port A completion and read data
//           b_*                            same as port A, for port B
//           mem_addr,mem_din,mem_w,mem_r   memory address/data/strobes
//           mem_dout                       memory read data
//           busy                           high in ACCESS and DONE
// Rev     : 1.0  initial release
// ============================================================================
module mem_arbiter2
   import mem_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_ack,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_ack,
   output logic [DATA_W-1:0] b_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   output logic              mem_w,
   output logic              mem_r,
   input  logic [DATA_W-1:0] mem_dout,
   output logic              busy
);

   state_e              state_q,    state_d;
   logic                sel_q,      sel_d;       // granted port
   logic                we_q,       we_d;
   logic                last_gnt_q, last_gnt_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;  // doubles as the latched address
   logic [DATA_W-1:0]   mem_din_q,  mem_din_d;   // doubles as the latched write data
   logic                mem_w_q,    mem_w_d;
   logic                mem_r_q,    mem_r_d;
   logic                a_ack_q,    a_ack_d;
   logic                b_ack_q,    b_ack_d;
   logic [DATA_W-1:0]   a_rdata_q,  a_rdata_d;
   logic [DATA_W-1:0]   b_rdata_q,  b_rdata_d;
   logic [1:0]          gnt;

   rr_pick2 u_rr_pick2 (
      .req      ({b_req, a_req}),
      .last_gnt (last_gnt_q),
      .gnt      (gnt)
   );

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      we_d       = we_q;
      last_gnt_d = last_gnt_q;
      mem_addr_d = mem_addr_q;
      mem_din_d  = mem_din_q;
      mem_w_d    = 1'b0;
      mem_r_d    = 1'b0;
      a_ack_d    = 1'b0;
      b_ack_d    = 1'b0;
      a_rdata_d  = a_rdata_q;
      b_rdata_d  = b_rdata_q;

      unique case (state_q)
         ST_IDLE: begin
            if (gnt != 2'b00) begin
               // Strobes are computed here so they are already registered
               // (and therefore glitch-free) for the whole ACCESS cycle.
               state_d    = ST_ACCESS;
               sel_d      = gnt[1];
               last_gnt_d = gnt[1];
               we_d       = gnt[1] ? b_we    : a_we;
               mem_addr_d = gnt[1] ? b_addr  : a_addr;
               mem_din_d  = gnt[1] ? b_wdata : a_wdata;
               mem_w_d    = gnt[1] ? b_we    : a_we;
               mem_r_d    = gnt[1] ? !b_we   : !a_we;
            end
         end
         ST_ACCESS: begin
            state_d = ST_DONE;
            a_ack_d = (sel_q == PORT_A);
            b_ack_d = (sel_q == PORT_B);
            if (!we_q) begin
               if (sel_q == PORT_A) a_rdata_d = mem_dout;
               else                 b_rdata_d = mem_dout;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         sel_q      <= PORT_A;
         we_q       <= 1'b0;
         last_gnt_q <= PORT_B;   // so A wins the first contention
         mem_addr_q <= '0;
         mem_din_q  <= '0;
         mem_w_q    <= 1'b0;
         mem_r_q    <= 1'b0;
         a_ack_q    <= 1'b0;
         b_ack_q    <= 1'b0;
         a_rdata_q  <= '0;
         b_rdata_q  <= '0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         we_q       <= we_d;
         last_gnt_q <= last_gnt_d;
         mem_addr_q <= mem_addr_d;
         mem_din_q  <= mem_din_d;
         mem_w_q    <= mem_w_d;
         mem_r_q    <= mem_r_d;
         a_ack_q    <= a_ack_d;
         b_ack_q    <= b_ack_d;
         a_rdata_q  <= a_rdata_d;
         b_rdata_q  <= b_rdata_d;
      end
   end

   assign mem_addr = mem_addr_q;
   assign mem_din  = mem_din_q;
   assign mem_w    = mem_w_q;
   assign mem_r    = mem_r_q;
   assign a_ack    = a_ack_q;
   assign b_ack    = b_ack_q;
   assign a_rdata  = a_rdata_q;
   assign b_rdata  = b_rdata_q;
   assign busy     = (state_q != ST_IDLE);

endmodule : mem_arbiter2
`default_nettype wire

// File: tb/tb_mem_arbiter2.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_arbiter2
// Purpose : Self-checking bench for mem_arbiter2 with a behavioural 128x32
//           memory. Single-port transactions come from a vector table; the
//           contention, reset-abort and stray-request cases are hand-written.
// Rev     : 1.0  initial release
// ============================================================================
module tb_mem_arbiter2;

   typedef struct {
      logic        port;      // 0 = A, 1 = B
      logic        we;
      logic [6:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata; // read result (ignored for writes)
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        a_req, a_we, b_req, b_we;
   logic [6:0]  a_addr, b_addr;
   logic [31:0] a_wdata, b_wdata;
   logic        a_ack, b_ack;
   logic [31:0] a_rdata, b_rdata;
   logic [6:0]  mem_addr;
   logic [31:0] mem_din, mem_dout;
   logic        mem_w, mem_r, busy;

   logic [31:0] mem [128];
   logic        fill;
   int          n_cmp = 0;
   int          n_err = 0;
   int          w_cnt = 0;
   int          viol  = 0;
   logic [31:0] exp_a, exp_b;
   vec_t        vecs [9];

   always #5 clk = ~clk;

   mem_arbiter2 dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .a_req    (a_req),
      .a_we     (a_we),
      .a_addr   (a_addr),
      .a_wdata  (a_wdata),
      .a_ack    (a_ack),
      .a_rdata  (a_rdata),
      .b_req    (b_req),
      .b_we     (b_we),
      .b_addr   (b_addr),
      .b_wdata  (b_wdata),
      .b_ack    (b_ack),
      .b_rdata  (b_rdata),
      .mem_addr (mem_addr),
      .mem_din  (mem_din),
      .mem_w    (mem_w),
      .mem_r    (mem_r),
      .mem_dout (mem_dout),
      .busy     (busy)
   );

   // Behavioural memory: asynchronous read, write on the edge closing W.
   always @(posedge clk) begin
      if (fill) begin
         for (int i = 0; i < 128; i++) mem[i] <= 32'hA500_0000 | i;
      end else if (mem_w) begin
         mem[mem_addr] <= mem_din;
      end
   end
   assign mem_dout = mem[mem_addr];

   // Strobe width and legality monitor.
   always @(negedge clk) begin
      if (mem_w) w_cnt++;
      if ((mem_w || mem_r) && (!busy || a_ack || b_ack)) viol++;
      if (mem_w && mem_r) viol++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic port, input logic req, input logic we,
                        input logic [6:0] addr, input logic [31:0] wdata);
      if (port == 1'b0) begin
         a_req = req; a_we = we; a_addr = addr; a_wdata = wdata;
      end else begin
         b_req = req; b_we = we; b_addr = addr; b_wdata = wdata;
      end
   endtask

   task automatic do_vec(input vec_t v);
      int          w0;
      logic        own_ack, oth_ack;
      logic [31:0] own_rd, oth_rd, oth_exp;
      w0 = w_cnt;
      drive(v.port, 1'b1, v.we, v.addr, v.wdata);
      step();  // ACCESS
      chk("access mem_w", {31'd0, mem_w}, {31'd0, v.we});
      chk("access mem_r", {31'd0, mem_r}, {31'd0, !v.we});
      chk("access mem_addr", {25'd0, mem_addr}, {25'd0, v.addr});
      if (v.we) chk("access mem_din", mem_din, v.wdata);
      chk("access acks", {30'd0, a_ack, b_ack}, 32'd0);
      chk("access busy", {31'd0, busy}, 32'd1);
      step();  // DONE
      own_ack = v.port ? b_ack : a_ack;
      oth_ack = v.port ? a_ack : b_ack;
      own_rd  = v.port ? b_rdata : a_rdata;
      oth_rd  = v.port ? a_rdata : b_rdata;
      if (!v.we) begin
         if (v.port) exp_b = v.exp_rdata; else exp_a = v.exp_rdata;
      end
      oth_exp = v.port ? exp_a : exp_b;
      chk("done own ack", {31'd0, own_ack}, 32'd1);
      chk("done other ack", {31'd0, oth_ack}, 32'd0);
      chk("done strobes", {30'd0, mem_w, mem_r}, 32'd0);
      chk("done own rdata", own_rd, v.port ? exp_b : exp_a);
      chk("done other rdata", oth_rd, oth_exp);
      drive(v.port, 1'b0, 1'b0, 7'd0, 32'd0);
      step();  // IDLE
      chk("idle acks", {30'd0, a_ack, b_ack}, 32'd0);
      chk("idle busy", {31'd0, busy}, 32'd0);
      chk("mem_w width", w_cnt - w0, v.we ? 32'd1 : 32'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      chk("reset outputs", {25'd0, a_ack, b_ack, mem_w, mem_r, busy, 2'b00},
          32'd0);
      chk("reset rdata", a_rdata | b_rdata, 32'd0);
      chk("reset mem_addr", {25'd0, mem_addr}, 32'd0);
      step();
      rst_n = 1'b1;
      exp_a = 32'd0;
      exp_b = 32'd0;
   endtask

   initial begin
      vecs[0] = '{1'b0, 1'b1, 7'd5,   32'hDEADBEEF, 32'h0};
      vecs[1] = '{1'b0, 1'b0, 7'd5,   32'h0,        32'hDEADBEEF};
      vecs[2] = '{1'b1, 1'b1, 7'd127, 32'h00000001, 32'h0};
      vecs[3] = '{1'b1, 1'b0, 7'd127, 32'h0,        32'h00000001};
      vecs[4] = '{1'b0, 1'b0, 7'd0,   32'h0,        32'hA5000000};
      vecs[5] = '{1'b1, 1'b0, 7'd64,  32'h0,        32'hA5000040};
      vecs[6] = '{1'b0, 1'b1, 7'd64,  32'hCAFEF00D, 32'h0};
      vecs[7] = '{1'b1, 1'b0, 7'd64,  32'h0,        32'hCAFEF00D};
      vecs[8] = '{1'b0, 1'b0, 7'd127, 32'h0,        32'h00000001};

      a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
      b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
      fill  = 1'b1;
      do_reset();
      fill  = 1'b0;

      // Single-port transactions, including both boundary addresses.
      for (int i = 0; i < 9; i++) do_vec(vecs[i]);

      // Continuous contention from reset: A, B, A, B, acks 3 cycles apart.
      do_reset();
      drive(1'b0, 1'b1, 1'b0, 7'd5,   32'd0);
      drive(1'b1, 1'b1, 1'b0, 7'd127, 32'd0);
      for (int e = 1; e <= 12; e++) begin
         step();
         chk("rr a_ack", {31'd0, a_ack}, {31'd0, (e == 2 || e == 8)});
         chk("rr b_ack", {31'd0, b_ack}, {31'd0, (e == 5 || e == 11)});
         chk("rr busy", {31'd0, busy}, {31'd0, (e % 3 != 0)});
         if (e == 1 || e == 7)  chk("rr addr A", {25'd0, mem_addr}, 32'd5);
         if (e == 4 || e == 10) chk("rr addr B", {25'd0, mem_addr}, 32'd127);
         if (e == 2 || e == 8)  chk("rr a_rdata", a_rdata, 32'hDEADBEEF);
         if (e == 5 || e == 11) chk("rr b_rdata", b_rdata, 32'h00000001);
         if (e == 11) begin
            drive(1'b0, 1'b0, 1'b0, 7'd0, 32'd0);
            drive(1'b1, 1'b0, 1'b0, 7'd0, 32'd0);
         end
      end
      exp_a = 32'hDEADBEEF;
      exp_b = 32'h00000001;

      // Stray B request during an A transaction must be ignored.
      drive(1'b0, 1'b1, 1'b0, 7'd5, 32'd0);
      step();  // A in ACCESS
      drive(1'b1, 1'b1, 1'b1, 7'd3, 32'hFFFFFFFF);
      step();  // A in DONE
      chk("stray a_ack", {31'd0, a_ack}, 32'd1);
      chk("stray b_ack", {31'd0, b_ack}, 32'd0);
      drive(1'b0, 1'b0, 1'b0, 7'd0, 32'd0);
      drive(1'b1, 1'b0, 1'b0, 7'd0, 32'd0);
      for (int k = 0; k < 4; k++) begin
         step();
         chk("stray idle", {29'd0, b_ack, busy, mem_w}, 32'd0);
      end
      do_vec('{1'b1, 1'b0, 7'd3, 32'h0, 32'hA5000003});

      // Reset in the middle of an A write's ACCESS cycle.
      drive(1'b0, 1'b1, 1'b1, 7'd10, 32'h12345678);
      step();
      chk("abort pre mem_w", {31'd0, mem_w}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort mem_w", {31'd0, mem_w}, 32'd0);
      chk("abort busy/ack", {29'd0, busy, a_ack, b_ack}, 32'd0);
      drive(1'b0, 1'b0, 1'b0, 7'd0, 32'd0);
      drive(1'b1, 1'b1, 1'b0, 7'd127, 32'd0);
      step();
      chk("abort held ack", {30'd0, a_ack, b_ack}, 32'd0);
      rst_n = 1'b1;
      exp_a = 32'd0;
      exp_b = 32'd0;
      step();  // B in ACCESS
      chk("post-reset B mem_r", {31'd0, mem_r}, 32'd1);
      chk("post-reset B addr", {25'd0, mem_addr}, 32'd127);
      step();  // B in DONE
      chk("post-reset b_ack", {31'd0, b_ack}, 32'd1);
      chk("post-reset a_ack", {31'd0, a_ack}, 32'd0);
      chk("post-reset b_rdata", b_rdata, 32'h00000001);
      drive(1'b1, 1'b0, 1'b0, 7'd0, 32'd0);
      step();
      chk("post-reset idle", {31'd0, busy}, 32'd0);

      chk("strobe legality", viol, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, expected completion");
      $fatal(1);
   end

endmodule : tb_mem_arbiter2
`default_nettype wire
